// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: state encodings,
// opcode/funct values, ALU operation classes and ALU function codes.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field to the
// ALU function code. Purely combinational.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [ALUOP_W-1:0]  aluop,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath: sequences each
// instruction and drives all mux selects, write enables and the ALU code.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                memwrite,
  output logic                irwrite,
  output logic                iord,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                pcen,
  output logic [STATE_W-1:0]  state
);

  state_t               state_q;
  state_t               state_d;
  logic [ALUOP_W-1:0]   aluop;
  logic                 pcwrite;
  logic                 branch;

  // State register; reset low forces FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; pcen is the only term that also depends on zero.
  always_comb begin
    memwrite = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
  end

  assign state = STATE_W'(state_q);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: a table of per-cycle
// {op, funct, zero, expected state, expected control bundle} records.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  mips_multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
  //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], pcen}
  logic [14:0] act;
  assign act = {memwrite, irwrite, iord, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, alucontrol, pcen};

  localparam logic [14:0] C_FETCH    = 15'b0_1_0_0_0_0_0_01_00_010_1;
  localparam logic [14:0] C_DECODE   = 15'b0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [14:0] C_ADRCALC  = 15'b0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [14:0] C_MEMREAD  = 15'b0_0_1_0_0_0_0_00_00_010_0;
  localparam logic [14:0] C_MEMWB    = 15'b0_0_0_0_1_1_0_00_00_010_0;
  localparam logic [14:0] C_MEMWRITE = 15'b1_0_1_0_0_0_0_00_00_010_0;
  localparam logic [14:0] C_EX_SLT   = 15'b0_0_0_0_0_0_1_00_00_111_0;
  localparam logic [14:0] C_EX_AND   = 15'b0_0_0_0_0_0_1_00_00_000_0;
  localparam logic [14:0] C_EX_OR    = 15'b0_0_0_0_0_0_1_00_00_001_0;
  localparam logic [14:0] C_EX_SUB   = 15'b0_0_0_0_0_0_1_00_00_110_0;
  localparam logic [14:0] C_EX_DFLT  = 15'b0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [14:0] C_ALUWB    = 15'b0_0_0_1_0_1_0_00_00_010_0;
  localparam logic [14:0] C_BEQ_T    = 15'b0_0_0_0_0_0_1_00_01_110_1;
  localparam logic [14:0] C_BEQ_NT   = 15'b0_0_0_0_0_0_1_00_01_110_0;
  localparam logic [14:0] C_ADDIWB   = 15'b0_0_0_0_0_1_0_00_00_010_0;
  localparam logic [14:0] C_JUMP     = 15'b0_0_0_0_0_0_0_00_10_010_1;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [14:0] ctrl;
  } vec_t;

  vec_t vecs[$];
  int   nvec;
  int   nerr;

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [3:0] s, input logic [14:0] c);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.st = s; v.ctrl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] s, input logic [14:0] c);
    nvec++;
    if (state !== s || act !== c) begin
      nerr++;
      $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
               name, state, act, s, c);
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b0;
    op    = 6'b111111;
    funct = 6'b000000;
    zero  = 1'b0;

    // Reset held low for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_hold", 4'd0, C_FETCH);
    end

    // lw
    add(6'b100011, 6'b0, 1'b0, 4'd1, C_DECODE);
    add(6'b100011, 6'b0, 1'b0, 4'd2, C_ADRCALC);
    add(6'b100011, 6'b0, 1'b0, 4'd3, C_MEMREAD);
    add(6'b100011, 6'b0, 1'b0, 4'd4, C_MEMWB);
    add(6'b100011, 6'b0, 1'b0, 4'd0, C_FETCH);
    // R-type slt, and, or, sub, unknown funct
    add(6'b000000, 6'b101010, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, 6'b101010, 1'b0, 4'd6, C_EX_SLT);
    add(6'b000000, 6'b101010, 1'b0, 4'd7, C_ALUWB);
    add(6'b000000, 6'b101010, 1'b0, 4'd0, C_FETCH);
    add(6'b000000, 6'b100100, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, 6'b100100, 1'b0, 4'd6, C_EX_AND);
    add(6'b000000, 6'b100100, 1'b0, 4'd7, C_ALUWB);
    add(6'b000000, 6'b100100, 1'b0, 4'd0, C_FETCH);
    add(6'b000000, 6'b100101, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, 6'b100101, 1'b0, 4'd6, C_EX_OR);
    add(6'b000000, 6'b100101, 1'b0, 4'd7, C_ALUWB);
    add(6'b000000, 6'b100101, 1'b0, 4'd0, C_FETCH);
    add(6'b000000, 6'b100010, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, 6'b100010, 1'b0, 4'd6, C_EX_SUB);
    add(6'b000000, 6'b100010, 1'b0, 4'd7, C_ALUWB);
    add(6'b000000, 6'b100010, 1'b0, 4'd0, C_FETCH);
    add(6'b000000, 6'b111100, 1'b0, 4'd1, C_DECODE);
    add(6'b000000, 6'b111100, 1'b0, 4'd6, C_EX_DFLT);
    add(6'b000000, 6'b111100, 1'b0, 4'd7, C_ALUWB);
    add(6'b000000, 6'b111100, 1'b0, 4'd0, C_FETCH);
    // beq taken, then not taken
    add(6'b000100, 6'b0, 1'b1, 4'd1, C_DECODE);
    add(6'b000100, 6'b0, 1'b1, 4'd8, C_BEQ_T);
    add(6'b000100, 6'b0, 1'b1, 4'd0, C_FETCH);
    add(6'b000100, 6'b0, 1'b0, 4'd1, C_DECODE);
    add(6'b000100, 6'b0, 1'b0, 4'd8, C_BEQ_NT);
    add(6'b000100, 6'b0, 1'b0, 4'd0, C_FETCH);
    // sw
    add(6'b101011, 6'b0, 1'b1, 4'd1, C_DECODE);
    add(6'b101011, 6'b0, 1'b1, 4'd2, C_ADRCALC);
    add(6'b101011, 6'b0, 1'b1, 4'd5, C_MEMWRITE);
    add(6'b101011, 6'b0, 1'b1, 4'd0, C_FETCH);
    // addi
    add(6'b001000, 6'b0, 1'b0, 4'd1, C_DECODE);
    add(6'b001000, 6'b0, 1'b0, 4'd9, C_ADRCALC);
    add(6'b001000, 6'b0, 1'b0, 4'd10, C_ADDIWB);
    add(6'b001000, 6'b0, 1'b0, 4'd0, C_FETCH);
    // j
    add(6'b000010, 6'b0, 1'b0, 4'd1, C_DECODE);
    add(6'b000010, 6'b0, 1'b0, 4'd11, C_JUMP);
    add(6'b000010, 6'b0, 1'b0, 4'd0, C_FETCH);
    // unsupported opcode is skipped
    add(6'b111111, 6'b0, 1'b0, 4'd1, C_DECODE);
    add(6'b111111, 6'b0, 1'b0, 4'd0, C_FETCH);

    // Release reset away from the rising edge; first edge goes to DECODE.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_release_fetch", 4'd0, C_FETCH);
    foreach (vecs[i]) begin
      op    = vecs[i].op;
      funct = vecs[i].funct;
      zero  = vecs[i].zero;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl);
    end

    // zero toggling inside BRANCH changes pcen without an edge.
    op = 6'b000100; zero = 1'b0;
    @(posedge clk); #1;
    check("beq_decode", 4'd1, C_DECODE);
    @(posedge clk); #1;
    check("beq_zero0", 4'd8, C_BEQ_NT);
    zero = 1'b1; #1;
    check("beq_zero_rise", 4'd8, C_BEQ_T);
    @(posedge clk); #1;
    check("beq_return", 4'd0, C_FETCH);

    // Asynchronous reset in the middle of MEMWRITE.
    op = 6'b101011; zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sw_memwrite", 4'd5, C_MEMWRITE);
    #2 reset = 1'b0;
    #1;
    check("async_reset_abort", 4'd0, C_FETCH);
    @(posedge clk); #1;
    check("async_reset_hold", 4'd0, C_FETCH);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart_decode", 4'd1, C_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
